nios2_nios2_oci_dct_packer: RTL and testbench
=============================================

NIOS2_NIOS2_OCI_DCT_PACKER -- requirements
Module: NIOS2_nios2_oci_dct_packer

Interface
REQ-001 Parameter: ATOM_W, default 2, width of one direct-control-transfer (DCT) atom.
REQ-002 Parameter: MAX_ATOMS, default 15, atoms per packet; buffer width BUF_W = ATOM_W*MAX_ATOMS (30); count width 4.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 trace_en  input  1  enables atom capture.
REQ-006 atom_valid  input  1  qualifies atom for one cycle.
REQ-007 atom  input  ATOM_W  encoded DCT outcome.
REQ-008 flush_req  input  1  indirect transfer or exception; force-close the partial packet.
REQ-009 test_ending  input  1  level; begin the end-of-test drain.
REQ-010 dct_buffer  output  BUF_W  live packing buffer.
REQ-011 dct_count  output  4  atoms currently in dct_buffer.
REQ-012 pkt_valid / pkt_ready  output / input  1 / 1  packet handshake; transfer occurs when both are high.
REQ-013 pkt_data / pkt_count  output  BUF_W / 4  closed packet and its atom count.
REQ-014 dct_overflow  output  1  one-cycle pulse when an atom is dropped.
REQ-015 test_has_ended  output  1  sticky; drain complete.

Function
REQ-016 Accepted atom: dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], atom}; dct_count += 1; the newest atom is in the LSBs.
REQ-017 Atom accepted iff atom_valid && trace_en && state==PACK && buffer space is available this cycle.
REQ-018 Close condition: (dct_count==MAX_ATOMS) or (flush_req && dct_count!=0) or (state==DRAIN && dct_count!=0).
REQ-019 Output slot free = !pkt_valid || pkt_ready; on close with slot free, pkt_data/pkt_count load the buffer next cycle, pkt_valid=1, and the buffer clears.
REQ-020 Close plus atom in the same cycle: the atom lands in the cleared buffer (dct_count=1, dct_buffer={0,atom}); no atom is lost.
REQ-021 Close blocked (slot busy): the buffer holds; when dct_count==MAX_ATOMS, an incoming atom is dropped and dct_overflow pulses the next cycle.
REQ-022 flush_req with dct_count==0 is a no-op; a blocked flush stays pending until the close succeeds.
REQ-023 pkt_data/pkt_count remain stable while pkt_valid && !pkt_ready; pkt_valid drops after the transfer unless reloaded in the same cycle.
REQ-024 trace_en low: atoms are ignored; buffer and packet state are retained.
REQ-025 FSM states: PACK -> DRAIN on test_ending; DRAIN ignores atoms and closes any partial buffer; DRAIN -> DONE when dct_count==0 && !pkt_valid; DONE is terminal until reset.
REQ-026 test_has_ended is 1 exactly in DONE, registered, and asserts the cycle after the final transfer.
REQ-027 One-cycle latency from accepted atom to dct_buffer/dct_count update, and from close to pkt_valid.

Reset
REQ-028 Reset sets: state=PACK, dct_buffer=0, dct_count=0, pkt_valid=0, pkt_data=0, pkt_count=0, dct_overflow=0, test_has_ended=0, and clears any pending flush.
REQ-029 Reset mid-packet or mid-drain discards all contents immediately; no packet is emitted.

Configuration
REQ-030 Macro NIOS2_OCI_DCT_OVF_CNT_EN defined: add output ovf_count[15:0], incremented per dropped atom, saturating at 0xFFFF, reset to 0.
REQ-031 Macro NIOS2_OCI_DCT_OVF_CNT_EN absent: no ovf_count port or logic; dct_overflow is still present.

Structure
REQ-032 Shared package NIOS2_oci_pkg holds the FSM state enum (PACK, DRAIN, DONE), the ATOM_W/MAX_ATOMS defaults, and the count-width constant.
REQ-033 One sub-module, NIOS2_nios2_oci_dct_outreg, is natural: a single-entry valid/ready output register.

Verification
REQ-034 15 atoms of 2'b01, pkt_ready=1 -> one packet: pkt_data=30'h15555555, pkt_count=15; then dct_count=0.
REQ-035 3 atoms (2'b10,2'b01,2'b11), then flush_req -> pkt_data=30'h00000027, pkt_count=3.
REQ-036 pkt_ready=0, 31 atoms -> first packet held stable, 15 atoms buffered, 1 dropped -> dct_overflow pulses once; ovf_count=1 when the macro is enabled.
REQ-037 15th atom and 16th atom on consecutive cycles, pkt_ready=1 -> packet emitted and dct_count=1 with no drop.
REQ-038 5 atoms, then test_ending -> packet pkt_count=5 emitted; test_has_ended=1 the cycle after the transfer; further atoms are ignored.
REQ-039 reset asserted with dct_count=7 and pkt_valid=1 -> all outputs 0 asynchronously; no packet is emitted after release.

Source files
------------

// File: rtl/nios2_nios2_oci_dct_packer_pkg.sv
// Shared definitions for the OCI DCT atom packer: FSM states and default sizes.
package nios2_nios2_oci_dct_packer_pkg;
    localparam int unsigned ATOM_W_DEF    = 2;
    localparam int unsigned MAX_ATOMS_DEF = 15;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        PACK,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/nios2_nios2_oci_dct_packer_outreg.sv
// Single-entry valid/ready output register holding one closed DCT packet.
module nios2_nios2_oci_dct_packer_outreg #(
    parameter int unsigned DATA_W = 30,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count,
    output logic              slot_free
);
    assign slot_free = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            count <= load_count;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/nios2_nios2_oci_dct_packer.sv
// Packs DCT atoms into fixed-size trace packets with flush and end-of-test drain.
// Optional saturating drop counter enabled by NIOS2_OCI_DCT_OVF_CNT_EN.
module nios2_nios2_oci_dct_packer
    import nios2_nios2_oci_dct_packer_pkg::*;
#(
    parameter int unsigned ATOM_W    = ATOM_W_DEF,
    parameter int unsigned MAX_ATOMS = MAX_ATOMS_DEF,
    parameter int unsigned BUF_W     = ATOM_W * MAX_ATOMS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_en,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom,
    input  logic              flush_req,
    input  logic              test_ending,
    input  logic              pkt_ready,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              pkt_valid,
    output logic [BUF_W-1:0]  pkt_data,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              dct_overflow,
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
    output logic [15:0]       ovf_count,
`endif
    output logic              test_has_ended
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ATOMS);

    state_t           state, next_state;
    logic             flush_pend;
    logic             full, nonempty, flush_eff, close, do_close;
    logic             offered, accept, drop, slot_free, valid_next;
    logic [BUF_W-1:0] buf_next;
    logic [CNT_W-1:0] cnt_next;

    assign full      = (dct_count == MAX_CNT);
    assign nonempty  = (dct_count != '0);
    assign flush_eff = flush_req || flush_pend;
    assign close     = full || (flush_eff && nonempty) || (state == DRAIN && nonempty);
    assign do_close  = close && slot_free;
    assign offered   = atom_valid && trace_en && (state == PACK);
    assign accept    = offered && (!full || do_close);
    assign drop      = offered && full && !do_close;
    assign valid_next = do_close || (pkt_valid && !pkt_ready);

    always_comb begin
        buf_next = dct_buffer;
        cnt_next = dct_count;
        if (do_close) begin
            buf_next = accept ? {{(BUF_W-ATOM_W){1'b0}}, atom} : '0;
            cnt_next = accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            buf_next = {dct_buffer[BUF_W-ATOM_W-1:0], atom};
            cnt_next = dct_count + CNT_W'(1);
        end
    end

    // Leaving DRAIN looks at next-cycle values so DONE shows the cycle after the last transfer.
    always_comb begin
        next_state = state;
        case (state)
            PACK:    if (test_ending) next_state = DRAIN;
            DRAIN:   if (cnt_next == '0 && !valid_next) next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = PACK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= PACK;
            dct_buffer   <= '0;
            dct_count    <= '0;
            flush_pend   <= 1'b0;
            dct_overflow <= 1'b0;
        end else begin
            state        <= next_state;
            dct_buffer   <= buf_next;
            dct_count    <= cnt_next;
            flush_pend   <= flush_eff && nonempty && !do_close;
            dct_overflow <= drop;
        end
    end

`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_count <= '0;
        else if (drop && ovf_count != '1)
            ovf_count <= ovf_count + 16'd1;
    end
`endif

    assign test_has_ended = (state == DONE);

    nios2_nios2_oci_dct_packer_outreg #(
        .DATA_W (BUF_W),
        .CNT_W  (CNT_W)
    ) u_outreg (
        .clk        (clk),
        .rst        (reset),
        .load       (do_close),
        .load_data  (dct_buffer),
        .load_count (dct_count),
        .ready      (pkt_ready),
        .valid      (pkt_valid),
        .data       (pkt_data),
        .count      (pkt_count),
        .slot_free  (slot_free)
    );
endmodule

// File: tb/tb_nios2_nios2_oci_dct_packer.sv
// Directed self-checking bench for the DCT packer.
module tb_nios2_nios2_oci_dct_packer;
    logic        clk = 1'b0;
    logic        reset, trace_en, atom_valid, flush_req, test_ending, pkt_ready;
    logic [1:0]  atom;
    logic [29:0] dct_buffer, pkt_data;
    logic [3:0]  dct_count, pkt_count;
    logic        pkt_valid, dct_overflow, test_has_ended;
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    nios2_nios2_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .trace_en       (trace_en),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .pkt_ready      (pkt_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .pkt_valid      (pkt_valid),
        .pkt_data       (pkt_data),
        .pkt_count      (pkt_count),
        .dct_overflow   (dct_overflow),
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
        .ovf_count      (ovf_count),
`endif
        .test_has_ended (test_has_ended)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs applied here take effect at the next rising edge; outputs are read 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".buf"}, 32'(dct_buffer), 32'h0);
        chk({tag, ".cnt"}, 32'(dct_count), 32'h0);
        chk({tag, ".pv"},  32'(pkt_valid), 32'h0);
        chk({tag, ".pd"},  32'(pkt_data), 32'h0);
        chk({tag, ".pc"},  32'(pkt_count), 32'h0);
        chk({tag, ".ovf"}, 32'(dct_overflow), 32'h0);
        chk({tag, ".end"}, 32'(test_has_ended), 32'h0);
    endtask

    initial begin
        reset = 1'b1; trace_en = 1'b0; atom_valid = 1'b0; atom = 2'b00;
        flush_req = 1'b0; test_ending = 1'b0; pkt_ready = 1'b1;
        #12;
        chk_all_zero("reset");
        reset = 1'b0;
        trace_en = 1'b1;
        tick();

        // 15 atoms of 01 fill one packet
        atom_valid = 1'b1; atom = 2'b01;
        for (int i = 0; i < 15; i++) tick();
        atom_valid = 1'b0;
        chk("fill.cnt", 32'(dct_count), 32'd15);
        chk("fill.buf", 32'(dct_buffer), 32'h15555555);
        chk("fill.pv_pre", 32'(pkt_valid), 32'h0);
        tick();
        chk("full.pv", 32'(pkt_valid), 32'h1);
        chk("full.pd", 32'(pkt_data), 32'h15555555);
        chk("full.pc", 32'(pkt_count), 32'd15);
        chk("full.cnt", 32'(dct_count), 32'd0);
        tick();
        chk("full.pv_drop", 32'(pkt_valid), 32'h0);

        // flush with empty buffer is a no-op
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        tick();
        chk("flush0.pv", 32'(pkt_valid), 32'h0);

        // three atoms then flush
        atom_valid = 1'b1;
        atom = 2'b10; tick();
        atom = 2'b01; tick();
        atom = 2'b11; tick();
        atom_valid = 1'b0;
        chk("flush.buf", 32'(dct_buffer), 32'h27);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        chk("flush.pv", 32'(pkt_valid), 32'h1);
        chk("flush.pd", 32'(pkt_data), 32'h27);
        chk("flush.pc", 32'(pkt_count), 32'd3);
        chk("flush.cnt", 32'(dct_count), 32'd0);
        tick();

        // 16 consecutive atoms: close and accept in the same cycle
        atom_valid = 1'b1; atom = 2'b11;
        for (int i = 0; i < 16; i++) tick();
        atom_valid = 1'b0;
        chk("c16.pv", 32'(pkt_valid), 32'h1);
        chk("c16.pd", 32'(pkt_data), 32'h3FFFFFFF);
        chk("c16.cnt", 32'(dct_count), 32'd1);
        chk("c16.buf", 32'(dct_buffer), 32'h3);
        tick();
        chk("c16.ovf", 32'(dct_overflow), 32'h0);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        chk("c16.tail_pc", 32'(pkt_count), 32'd1);
        tick();

        // backpressure: 31 atoms, one dropped
        pkt_ready = 1'b0;
        atom_valid = 1'b1; atom = 2'b01;
        for (int i = 0; i < 15; i++) tick();
        atom = 2'b10;
        for (int i = 0; i < 15; i++) tick();
        chk("bp.pd_held", 32'(pkt_data), 32'h15555555);
        chk("bp.ovf_pre", 32'(dct_overflow), 32'h0);
        atom = 2'b11; tick();
        atom_valid = 1'b0;
        chk("bp.ovf", 32'(dct_overflow), 32'h1);
        chk("bp.cnt", 32'(dct_count), 32'd15);
        chk("bp.buf", 32'(dct_buffer), 32'h2AAAAAAA);
        chk("bp.pv", 32'(pkt_valid), 32'h1);
        chk("bp.pc", 32'(pkt_count), 32'd15);
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
        chk("bp.ovf_count", 32'(ovf_count), 32'd1);
`endif
        tick();
        chk("bp.ovf_pulse", 32'(dct_overflow), 32'h0);
        chk("bp.pd_still", 32'(pkt_data), 32'h15555555);
        pkt_ready = 1'b1; tick();
        chk("bp.reload_pv", 32'(pkt_valid), 32'h1);
        chk("bp.reload_pd", 32'(pkt_data), 32'h2AAAAAAA);
        chk("bp.reload_cnt", 32'(dct_count), 32'd0);
        tick();
        chk("bp.done_pv", 32'(pkt_valid), 32'h0);

        // async reset with a held packet and 7 buffered atoms
        pkt_ready = 1'b0;
        atom_valid = 1'b1; atom = 2'b11;
        tick(); tick();
        atom_valid = 1'b0;
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        atom_valid = 1'b1; atom = 2'b01;
        for (int i = 0; i < 7; i++) tick();
        atom_valid = 1'b0;
        chk("rst.pre_cnt", 32'(dct_count), 32'd7);
        chk("rst.pre_buf", 32'(dct_buffer), 32'h1555);
        chk("rst.pre_pv", 32'(pkt_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("rst.async");
        tick();
        reset = 1'b0; pkt_ready = 1'b1;
        tick(); tick();
        chk("rst.no_pkt", 32'(pkt_valid), 32'h0);
        chk("rst.cnt", 32'(dct_count), 32'd0);

        // end-of-test drain
        atom_valid = 1'b1; atom = 2'b10;
        for (int i = 0; i < 5; i++) tick();
        atom_valid = 1'b0;
        test_ending = 1'b1; tick();
        chk("drain.cnt_hold", 32'(dct_count), 32'd5);
        chk("drain.end0", 32'(test_has_ended), 32'h0);
        tick();
        chk("drain.pv", 32'(pkt_valid), 32'h1);
        chk("drain.pc", 32'(pkt_count), 32'd5);
        chk("drain.pd", 32'(pkt_data), 32'h2AA);
        chk("drain.end1", 32'(test_has_ended), 32'h0);
        tick();
        chk("drain.pv_drop", 32'(pkt_valid), 32'h0);
        chk("drain.ended", 32'(test_has_ended), 32'h1);
        test_ending = 1'b0;
        atom_valid = 1'b1; atom = 2'b11; tick(); tick();
        atom_valid = 1'b0;
        chk("done.ignore", 32'(dct_count), 32'd0);
        chk("done.sticky", 32'(test_has_ended), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
